// File: rtl/msg_assembler.sv
// Byte-stream frame assembler: finds SYNC_BYTE, collects a 21-byte payload, checks the XOR checksum,
// and publishes good payloads on msg. Good and bad frames are counted, and both counters saturate.
module msg_assembler #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [167:0] msg,
    output logic         msg_valid,
    output logic [15:0]  frames_ok,
    output logic [15:0]  frames_bad
);
    // state   | meaning
    // IDLE    | hunting for SYNC_BYTE, other bytes dropped
    // PAYLOAD | collecting the 21 payload bytes
    // CHECK   | waiting for the checksum byte
    // DONE    | one-cycle publish slot, rx_ready held low
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   IDLE_LOAD = TW'(TIMEOUT - 1);
    localparam logic [4:0]      LAST_BYTE = 5'd20;

    logic [1:0]    state;
    logic [4:0]    byte_cnt;
    logic [7:0]    csum;
    logic [167:0]  shadow;
    logic [TW-1:0] idle_cnt;
    logic          accept;
    logic          timeout_hit;

    assign accept      = rx_valid && rx_ready;
    // Down-counter reaches zero after TIMEOUT-1 idle cycles, so the next idle cycle is the TIMEOUT-th.
    assign timeout_hit = !accept && (idle_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            csum       <= '0;
            shadow     <= '0;
            idle_cnt   <= '0;
            msg        <= '0;
            msg_valid  <= 1'b0;
            rx_ready   <= 1'b1;
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            msg_valid <= 1'b0;
            rx_ready  <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state    <= PAYLOAD;
                        byte_cnt <= '0;
                        csum     <= '0;
                        idle_cnt <= IDLE_LOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        // Shift in from the top so byte 0 ends up in [7:0] after 21 bytes.
                        shadow   <= {rx_data, shadow[167:8]};
                        csum     <= csum ^ rx_data;
                        idle_cnt <= IDLE_LOAD;
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= CHECK;
                        end
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            msg       <= shadow;
                            msg_valid <= 1'b1;
                            rx_ready  <= 1'b0;
                            state     <= DONE;
                            if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
                        end else begin
                            state <= IDLE;
                            if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
                        end
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/msg_assembler.md
MSG_ASSEMBLER -- requirements
Module: msg_assembler

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT, default 1000, the maximum number of consecutive mid-frame cycles with no accepted byte.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  incoming byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data is valid this cycle.
REQ-007 SHALL have port rx_ready  output  1  block can accept a byte; a byte is accepted when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port msg  output  168  last good message, held stable between updates.
REQ-009 SHALL have port msg_valid  output  1  one-cycle pulse marking a new msg.
REQ-010 SHALL have port frames_ok  output  16  count of good frames, saturating.
REQ-011 SHALL have port frames_bad  output  16  count of checksum and timeout failures, saturating.

Function
REQ-012 SHALL frame each message on the wire as: SYNC_BYTE, 21 payload bytes, 1 checksum byte.
REQ-013 SHALL write payload byte k (k=0..20) into msg bits [8k+7:8k], so byte 0 lands in msg[7:0].
- Resulting field map: type [7:0], seq [39:8], side [47:40], price [111:80], qty [143:112].
REQ-014 SHALL define the checksum as the XOR of all 21 payload bytes; SYNC_BYTE is excluded.
REQ-015 SHALL implement the states IDLE, PAYLOAD, CHECK and DONE.
REQ-016 IDLE SHALL discard every accepted byte other than SYNC_BYTE.
- On an accepted SYNC_BYTE: go to PAYLOAD, clear the byte count, clear the running checksum.
REQ-017 PAYLOAD SHALL, on each accepted byte, store it into a shadow register and XOR it into the running checksum.
- SYNC_BYTE values inside the payload are treated as ordinary data.
- After the 21st payload byte, go to CHECK.
REQ-018 CHECK, on an accepted byte equal to the running checksum, SHALL on that same clock edge:
- copy the shadow register to msg;
- set msg_valid to 1;
- increment frames_ok;
- go to DONE.
REQ-019 CHECK, on an accepted mismatching byte, SHALL increment frames_bad, leave msg unchanged, and go to IDLE.
REQ-020 DONE SHALL last exactly one cycle, drive rx_ready=0, and then go to IDLE; msg_valid returns to 0 on leaving DONE.
REQ-021 rx_ready SHALL be 1 in every state except DONE.
REQ-022 SHALL keep an idle-cycle counter in PAYLOAD and CHECK that clears on every accepted byte.
- When TIMEOUT consecutive cycles pass with no accepted byte: increment frames_bad, discard the partial frame, go to IDLE.
REQ-023 msg SHALL change only on a good frame (REQ-018); partial and failed frames never alter msg.
REQ-024 frames_ok and frames_bad SHALL saturate at 16'hFFFF.
REQ-025 All outputs SHALL be registered; latency from the clock edge accepting the checksum byte to msg_valid high is that same edge.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL:
- set state=IDLE;
- set msg=0, msg_valid=0, frames_ok=0, frames_bad=0;
- clear byte count, checksum and idle counter;
- take rx_ready=1 in the following cycle.
REQ-027 rst SHALL override all other activity, including mid-frame and in DONE; the partial frame is discarded and is not counted as bad.

Verification
REQ-028 Good frame: A5, then payload with type=00, seq=0, side=00, price=100, qty=5, all other bytes 00, then checksum 0x61 (0x64 XOR 0x05).
- Expect: msg_valid high for exactly 1 cycle; msg[111:80]=100; msg[143:112]=5; frames_ok=1; rx_ready=0 for that 1 cycle.
REQ-029 Bad checksum: the frame of REQ-028 with checksum 0x60.
- Expect: no msg_valid; msg keeps its previous value; frames_bad=1.
REQ-030 Timeout, with TIMEOUT=16: A5 plus 10 payload bytes, then rx_valid=0 for 16 cycles.
- Expect: frames_bad=1 and state IDLE.
- Then send the REQ-028 frame: it is accepted and frames_ok=1.
REQ-031 Leading garbage and embedded sync: 00, 13, then a good frame whose payload contains A5 bytes.
- Expect: exactly one msg_valid, payload stored verbatim, frames_ok=1.
REQ-032 Reset mid-frame: rst pulsed after A5 plus 5 payload bytes, then the remaining bytes of that frame are sent.
- Expect: counters 0; no msg_valid from the remaining bytes; the next full frame is accepted.
REQ-033 Gapped input: rx_valid low for 15 cycles between each payload byte, with TIMEOUT=16.
- Expect: the frame completes; frames_ok=1; frames_bad=0.
